// File: rtl/evt10_capture.sv
// evt10_capture: ten-channel sticky rising-edge capture feeding the OR10 macro.
// Each channel samples its event input, detects a rising edge and holds it in
// a sticky flag Qn until the matching Cn clear. CNT is the registered
// population count of the flags and always agrees with Q0..Q9.
//
// Optional build macro: EVT10_SYNC_EN
//   defined   - each An passes through a 2-flop synchronizer before Sn
//   undefined - An feeds Sn directly (sources already synchronous to CK)

module evt10_capture (
    input  logic       CK,
    input  logic       CD,
    input  logic       EN,
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       A5,
    input  logic       A6,
    input  logic       A7,
    input  logic       A8,
    input  logic       A9,
    input  logic       C0,
    input  logic       C1,
    input  logic       C2,
    input  logic       C3,
    input  logic       C4,
    input  logic       C5,
    input  logic       C6,
    input  logic       C7,
    input  logic       C8,
    input  logic       C9,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic       Q4,
    output logic       Q5,
    output logic       Q6,
    output logic       Q7,
    output logic       Q8,
    output logic       Q9,
    output logic [3:0] CNT
);

    // Counts asserted bits of a 10-bit flag vector (result 0..10).
    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [9:0] a_vec;
    logic [9:0] c_vec;
    logic [9:0] s_in;
    logic [9:0] s_reg;
    logic [9:0] p_reg;
    logic [9:0] edge_det;
    logic [9:0] q_reg;
    logic [9:0] q_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    assign a_vec = {A9, A8, A7, A6, A5, A4, A3, A2, A1, A0};
    assign c_vec = {C9, C8, C7, C6, C5, C4, C3, C2, C1, C0};

`ifdef EVT10_SYNC_EN
    logic [9:0] sync_1;
    logic [9:0] sync_2;

    // Two-flop synchronizer bringing the asynchronous event inputs into CK.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= a_vec;
            sync_2 <= sync_1;
        end
    end

    assign s_in = sync_2;
`else
    assign s_in = a_vec;
`endif

    // Sample and previous registers; they track the input regardless of EN so
    // that enabling capture with a steady-high input does not fake an edge.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            s_reg <= '0;
            p_reg <= '0;
        end else begin
            s_reg <= s_in;
            p_reg <= s_reg;
        end
    end

    assign edge_det = s_reg & ~p_reg;

    // Flag next state (set wins over clear) and the matching population count.
    always_comb begin
        q_next   = '0;
        cnt_next = 4'd0;
        q_next   = (edge_det & {10{EN}}) | (q_reg & ~c_vec);
        cnt_next = popcount10(q_next);
    end

    // Sticky flags and their count, both registered so no input reaches Q/CNT combinationally.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            q_reg   <= '0;
            cnt_reg <= 4'd0;
        end else begin
            q_reg   <= q_next;
            cnt_reg <= cnt_next;
        end
    end

    assign Q0  = q_reg[0];
    assign Q1  = q_reg[1];
    assign Q2  = q_reg[2];
    assign Q3  = q_reg[3];
    assign Q4  = q_reg[4];
    assign Q5  = q_reg[5];
    assign Q6  = q_reg[6];
    assign Q7  = q_reg[7];
    assign Q8  = q_reg[8];
    assign Q9  = q_reg[9];
    assign CNT = cnt_reg;

endmodule

// File: tb/tb_evt10_capture.sv
// tb_evt10_capture: directed self-checking bench for evt10_capture.
// Works in either build; LAT is the number of edges from the sampling edge
// of an input change to the edge before the flag edge.

module tb_evt10_capture;

`ifdef EVT10_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       ck;
    logic       cd;
    logic       en;
    logic [9:0] a;
    logic [9:0] c;
    wire  [9:0] q;
    wire  [3:0] cnt;

    int checks;
    int failures;

    evt10_capture dut (
        .CK (ck),   .CD (cd),   .EN (en),
        .A0 (a[0]), .A1 (a[1]), .A2 (a[2]), .A3 (a[3]), .A4 (a[4]),
        .A5 (a[5]), .A6 (a[6]), .A7 (a[7]), .A8 (a[8]), .A9 (a[9]),
        .C0 (c[0]), .C1 (c[1]), .C2 (c[2]), .C3 (c[3]), .C4 (c[4]),
        .C5 (c[5]), .C6 (c[6]), .C7 (c[7]), .C8 (c[8]), .C9 (c[9]),
        .Q0 (q[0]), .Q1 (q[1]), .Q2 (q[2]), .Q3 (q[3]), .Q4 (q[4]),
        .Q5 (q[5]), .Q6 (q[6]), .Q7 (q[7]), .Q8 (q[8]), .Q9 (q[9]),
        .CNT(cnt)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic test_reset();
        cd = 1'b1;
        en = 1'b1;
        a  = 10'h3FF;
        c  = 10'h000;
        tick(3);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL reset_q got=%h want=%h", q, 10'h000);
        end
        checks++;
        if (cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_cnt got=%0d want=%0d", cnt, 0);
        end
        cd = 1'b0;
        tick(LAT);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL release_early_q got=%h want=%h", q, 10'h000);
        end
        tick(1);
        checks++;
        if (q !== 10'h3FF) begin
            failures++;
            $display("[TB] FAIL release_all_q got=%h want=%h", q, 10'h3FF);
        end
        checks++;
        if (cnt !== 4'd10) begin
            failures++;
            $display("[TB] FAIL release_all_cnt got=%0d want=%0d", cnt, 10);
        end
        c = 10'h3FF;
        tick(1);
        c = 10'h000;
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL clear_all got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
    endtask

    task automatic test_single_event();
        a = 10'h000;
        tick(LAT + 2);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL single_idle_q got=%h want=%h", q, 10'h000);
        end
        a[3] = 1'b1;
        tick(LAT);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL single_early_q got=%h want=%h", q, 10'h000);
        end
        tick(1);
        checks++;
        if (q !== 10'h008 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL single_set got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h008, 1);
        end
        tick(3);
        checks++;
        if (q !== 10'h008 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL single_hold got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h008, 1);
        end
        c[3] = 1'b1;
        tick(1);
        c[3] = 1'b0;
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL single_clear got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
    endtask

    task automatic test_collision();
        a[5] = 1'b1;
        tick(LAT + 1);
        checks++;
        if (q !== 10'h020 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL coll_first got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h020, 1);
        end
        a[5] = 1'b0;
        tick(LAT + 1);
        a[5] = 1'b1;
        tick(LAT);
        c[5] = 1'b1;
        tick(1);
        checks++;
        if (q !== 10'h020 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL coll_set_wins got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h020, 1);
        end
        tick(1);
        c[5] = 1'b0;
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL coll_then_clear got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
    endtask

    task automatic test_enable_gating();
        en   = 1'b0;
        a[7] = 1'b1;
        tick(LAT + 2);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL gate_disabled got=%h want=%h", q, 10'h000);
        end
        en = 1'b1;
        tick(LAT + 2);
        checks++;
        if (q !== 10'h000) begin
            failures++;
            $display("[TB] FAIL gate_enable_high got=%h want=%h", q, 10'h000);
        end
        a[7] = 1'b0;
        tick(LAT + 1);
        a[7] = 1'b1;
        tick(LAT + 1);
        checks++;
        if (q !== 10'h080 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL gate_reedge got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h080, 1);
        end
        en   = 1'b0;
        c[7] = 1'b1;
        tick(1);
        c[7] = 1'b0;
        en   = 1'b1;
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL gate_clear_disabled got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
    endtask

    task automatic test_multi_channel();
        a[2] = 1'b1;
        tick(LAT + 1);
        checks++;
        if (q !== 10'h004 || cnt !== 4'd1) begin
            failures++;
            $display("[TB] FAIL multi_pre got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h004, 1);
        end
        a[0] = 1'b1;
        a[4] = 1'b1;
        a[9] = 1'b1;
        tick(LAT);
        c[2] = 1'b1;
        tick(1);
        c[2] = 1'b0;
        checks++;
        if (q !== 10'b10_0001_0001 || cnt !== 4'd3) begin
            failures++;
            $display("[TB] FAIL multi_mix got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h211, 3);
        end
    endtask

    task automatic test_reset_mid();
        c = 10'h3FF;
        tick(1);
        c = 10'h000;
        a = 10'h000;
        tick(LAT + 1);
        a = 10'h0FF;
        tick(LAT + 1);
        checks++;
        if (q !== 10'h0FF || cnt !== 4'd8) begin
            failures++;
            $display("[TB] FAIL mid_pre got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h0FF, 8);
        end
        a[9] = 1'b1;
        tick(1);
        #2;
        cd = 1'b1;
        #1;
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL mid_async got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
        a = 10'h000;
        tick(2);
        cd = 1'b0;
        tick(LAT + 3);
        checks++;
        if (q !== 10'h000 || cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL mid_no_ghost got q=%h cnt=%0d want q=%h cnt=%0d", q, cnt, 10'h000, 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cd = 1'b1;
        en = 1'b0;
        a  = 10'h000;
        c  = 10'h000;
        test_reset();
        test_single_event();
        test_collision();
        test_enable_gating();
        test_multi_channel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
